// File: rtl/sprite_ram_loader.sv
// Sprite RAM loader: takes a raster-ordered pixel stream over valid/ready and
// writes it into the 64x64 (by default) sprite RAM, one registered write per
// accepted beat, address packed {row, col} to match the VGA read path.
module sprite_ram_loader #(
  parameter int DATA_W    = 8,
  parameter int SIDE_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [2*SIDE_BITS-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  localparam int AW = 2*SIDE_BITS;
  localparam logic [SIDE_BITS-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [SIDE_BITS-1:0]  row_q, row_d;
  logic [SIDE_BITS-1:0]  col_q, col_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  accept;
  logic                  last_beat;

  // Handshake, counter advance and next-state logic; the write port is a
  // one-stage register stage behind the accept.
  always_comb begin
    busy      = (state_q == LOAD);
    // abort blocks the handshake so no beat slips in during the cancel cycle
    in_ready  = busy & ~abort;
    accept    = in_valid & in_ready;
    last_beat = (row_q == '1) && (col_q == '1);

    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = accept & last_beat;
    aborted_d = 1'b0;

    if (accept) begin
      wr_addr_d = {row_q, col_q};
      wr_data_d = in_data;
    end

    case (state_q)
      IDLE: begin
        // abort is meaningless here, so start wins even if both are high
        if (start) begin
          state_d = LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (accept) begin
          col_d = col_q + CNT_ONE;
          if (col_q == '1) row_d = row_q + CNT_ONE;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and write-port registers; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
